// File: rtl/keypad_emulator_if.sv
// rtl/keypad_emulator_if.sv - request and row-scan bundle for the keypad emulator
interface keypad_emulator_if;
    logic [3:0] key_code;
    logic       press_req;
    logic       release_req;
    logic [3:0] row;
    logic [3:0] col;
    logic       busy;
    logic       key_down;
    logic       done;

    modport master (
        output key_code, press_req, release_req, row,
        input  col, busy, key_down, done
    );

    modport slave (
        input  key_code, press_req, release_req, row,
        output col, busy, key_down, done
    );
endinterface

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 matrix keypad model with deterministic contact bounce
module keypad_emulator #(
    parameter int BOUNCE_CYCLES = 8,
    parameter int BOUNCE_PERIOD = 4
) (
    input  logic              clk,
    input  logic              reset,
    keypad_emulator_if.slave  bus
);
    localparam int CYC_W    = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
    localparam int SEG_W    = (BOUNCE_CYCLES > 0) ? $clog2(BOUNCE_CYCLES + 1) : 1;
    localparam int CYC_LAST = (BOUNCE_PERIOD > 1) ? BOUNCE_PERIOD - 1 : 0;
    localparam int SEG_LAST = (BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0;
    localparam bit NO_BOUNCE = (BOUNCE_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_BOUNCE,
        S_HELD,
        S_RELEASE_BOUNCE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_contact, w_contact_nxt;
    logic [3:0]       r_key, w_key_nxt;
    logic [SEG_W-1:0] r_seg, w_seg_nxt;
    logic [CYC_W-1:0] r_cyc, w_cyc_nxt;
    logic             r_done, w_done_nxt;
    logic             w_seg_end;
    logic             w_bounce_end;
    logic [SEG_W-1:0] w_seg_inc;
    logic [3:0]       w_col;

    assign w_seg_end    = (r_cyc == CYC_W'(CYC_LAST));
    assign w_bounce_end = w_seg_end && (r_seg == SEG_W'(SEG_LAST));
    assign w_seg_inc    = r_seg + SEG_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_contact <= 1'b0;
            r_key     <= 4'h0;
            r_seg     <= '0;
            r_cyc     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_contact <= w_contact_nxt;
            r_key     <= w_key_nxt;
            r_seg     <= w_seg_nxt;
            r_cyc     <= w_cyc_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_contact_nxt = r_contact;
        w_key_nxt     = r_key;
        w_seg_nxt     = r_seg;
        w_cyc_nxt     = r_cyc;
        w_done_nxt    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.press_req) begin
                    w_key_nxt     = bus.key_code;
                    w_seg_nxt     = '0;
                    w_cyc_nxt     = '0;
                    w_contact_nxt = 1'b1;
                    if (NO_BOUNCE) begin
                        w_state_nxt = S_HELD;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_PRESS_BOUNCE;
                    end
                end
            end
            // Press bounce starts closed: even segments make contact.
            S_PRESS_BOUNCE: begin
                if (w_bounce_end) begin
                    w_state_nxt   = S_HELD;
                    w_contact_nxt = 1'b1;
                    w_seg_nxt     = '0;
                    w_cyc_nxt     = '0;
                    w_done_nxt    = 1'b1;
                end else if (w_seg_end) begin
                    w_seg_nxt     = w_seg_inc;
                    w_cyc_nxt     = '0;
                    w_contact_nxt = ~w_seg_inc[0];
                end else begin
                    w_cyc_nxt = r_cyc + CYC_W'(1);
                end
            end
            S_HELD: begin
                w_contact_nxt = 1'b1;
                if (bus.release_req) begin
                    w_seg_nxt     = '0;
                    w_cyc_nxt     = '0;
                    w_contact_nxt = 1'b0;
                    if (NO_BOUNCE) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_RELEASE_BOUNCE;
                    end
                end
            end
            S_RELEASE_BOUNCE: begin
                if (w_bounce_end) begin
                    w_state_nxt   = S_IDLE;
                    w_contact_nxt = 1'b0;
                    w_seg_nxt     = '0;
                    w_cyc_nxt     = '0;
                    w_done_nxt    = 1'b1;
                end else if (w_seg_end) begin
                    w_seg_nxt     = w_seg_inc;
                    w_cyc_nxt     = '0;
                    w_contact_nxt = w_seg_inc[0];
                end else begin
                    w_cyc_nxt = r_cyc + CYC_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Combinational so a scanner stepping rows sees the column in the same cycle.
    always_comb begin
        w_col = 4'b0000;
        if (r_contact && bus.row[r_key[3:2]]) begin
            w_col[r_key[1:0]] = 1'b1;
        end
    end

    assign bus.col      = w_col;
    assign bus.busy     = (r_state == S_PRESS_BOUNCE) || (r_state == S_RELEASE_BOUNCE);
    assign bus.key_down = (r_state == S_HELD);
    assign bus.done     = r_done;
endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - bench for keypad_emulator with bounce and no-bounce instances
module tb_keypad_emulator;
    localparam int BC = 8;
    localparam int BP = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    keypad_emulator_if bus ();
    keypad_emulator_if bus0 ();

    keypad_emulator #(.BOUNCE_CYCLES(BC), .BOUNCE_PERIOD(BP)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    keypad_emulator #(.BOUNCE_CYCLES(0), .BOUNCE_PERIOD(BP)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int done0_cnt = 0;
    int busy0_cnt = 0;

    // Reference: mode 0 idle, 1 pressing, 2 held, 3 releasing; time since request in m_el.
    int         m_mode [2];
    int         m_el   [2];
    logic [3:0] m_key  [2];
    logic       m_done [2];
    int         m_total[2];

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_el[i]   = 0;
            m_key[i]  = 4'h0;
            m_done[i] = 1'b0;
        end
    endfunction

    function automatic void model_step(input int i, input logic p, input logic r, input logic [3:0] kc);
        m_done[i] = 1'b0;
        case (m_mode[i])
            0: if (p) begin
                m_key[i] = kc;
                m_el[i]  = 0;
                if (m_total[i] == 0) begin m_mode[i] = 2; m_done[i] = 1'b1; end
                else m_mode[i] = 1;
            end
            1: begin
                m_el[i]++;
                if (m_el[i] == m_total[i]) begin m_mode[i] = 2; m_done[i] = 1'b1; end
            end
            2: if (r) begin
                m_el[i] = 0;
                if (m_total[i] == 0) begin m_mode[i] = 0; m_done[i] = 1'b1; end
                else m_mode[i] = 3;
            end
            default: begin
                m_el[i]++;
                if (m_el[i] == m_total[i]) begin m_mode[i] = 0; m_done[i] = 1'b1; end
            end
        endcase
    endfunction

    function automatic logic [3:0] model_col(input int i, input logic [3:0] rw);
        logic       c;
        logic [3:0] res;
        logic [3:0] k;
        res = 4'b0000;
        k   = m_key[i];
        case (m_mode[i])
            1:       c = ((m_el[i] / BP) % 2) == 0;
            2:       c = 1'b1;
            3:       c = ((m_el[i] / BP) % 2) == 1;
            default: c = 1'b0;
        endcase
        if (c && rw[k[3:2]]) res[k[1:0]] = 1'b1;
        return res;
    endfunction

    task automatic check_all();
        chk("model_col",       bus.col,       model_col(0, bus.row));
        chk("model_busy",      bus.busy,      m_mode[0] == 1 || m_mode[0] == 3);
        chk("model_key_down",  bus.key_down,  m_mode[0] == 2);
        chk("model_done",      bus.done,      m_done[0]);
        chk("model0_col",      bus0.col,      model_col(1, bus0.row));
        chk("model0_busy",     bus0.busy,     1'b0);
        chk("model0_key_down", bus0.key_down, m_mode[1] == 2);
        chk("model0_done",     bus0.done,     m_done[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0, bus.press_req, bus.release_req, bus.key_code);
        model_step(1, bus0.press_req, bus0.release_req, bus0.key_code);
        @(negedge clk);
        check_all();
        if (bus.done)  done_cnt++;
        if (bus0.done) done0_cnt++;
        if (bus0.busy) busy0_cnt++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        m_total[0] = BC * BP;
        m_total[1] = 0;
        tbl.push_back('{4'b0001, 4'b0000});
        tbl.push_back('{4'b0010, 4'b0100});
        tbl.push_back('{4'b0100, 4'b0000});
        tbl.push_back('{4'b1000, 4'b0000});
        tbl.push_back('{4'b0011, 4'b0100});
        tbl.push_back('{4'b1111, 4'b0100});
        tbl.push_back('{4'b0000, 4'b0000});

        reset = 1'b1;
        bus.key_code = 4'h0;  bus.press_req = 1'b0;  bus.release_req = 1'b0;  bus.row = 4'b0000;
        bus0.key_code = 4'h0; bus0.press_req = 1'b0; bus0.release_req = 1'b0; bus0.row = 4'b0000;
        model_reset();

        #12;
        chk("rst_col", bus.col, 4'b0000);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_key_down", bus.key_down, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        #8;
        reset = 1'b0;

        // Reset arriving mid press bounce must drop col immediately.
        bus.key_code = 4'h6; bus.row = 4'b0010; bus.press_req = 1'b1;
        cycle();
        bus.press_req = 1'b0;
        cycle();
        chk("pre_rst_col", bus.col, 4'b0100);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_col", bus.col, 4'b0000);
        chk("async_rst_busy", bus.busy, 1'b0);
        chk("async_rst_done", bus.done, 1'b0);
        model_reset();
        #17 reset = 1'b0;
        done_cnt = 0;
        run(3);
        chk("post_rst_busy", bus.busy, 1'b0);
        chk("post_rst_key_down", bus.key_down, 1'b0);
        chk("post_rst_done_cnt", done_cnt, 0);

        // Press key 6, row 1 driven: bounce 1,0,1,0 in 4-cycle segments.
        done_cnt = 0;
        bus.key_code = 4'h6; bus.row = 4'b0010; bus.press_req = 1'b1;
        for (int k = 0; k < BC * BP; k++) begin
            cycle();
            bus.press_req = 1'b0;
            chk("press_col", bus.col, ((k / BP) % 2 == 0) ? 4'b0100 : 4'b0000);
            chk("press_busy", bus.busy, 1'b1);
        end
        cycle();
        chk("held_key_down", bus.key_down, 1'b1);
        chk("held_col", bus.col, 4'b0100);
        chk("held_done", bus.done, 1'b1);
        chk("held_busy", bus.busy, 1'b0);
        cycle();
        chk("held_done_drop", bus.done, 1'b0);
        chk("press_done_cnt", done_cnt, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.row = tbl[i].row;
            #1;
            chk("held_row_table", bus.col, tbl[i].col);
            cycle();
        end

        // Release: bounce 0,1,0,1 then idle.
        done_cnt = 0;
        bus.row = 4'b0010; bus.release_req = 1'b1;
        for (int k = 0; k < BC * BP; k++) begin
            cycle();
            bus.release_req = 1'b0;
            chk("release_col", bus.col, ((k / BP) % 2 == 1) ? 4'b0100 : 4'b0000);
            chk("release_busy", bus.busy, 1'b1);
        end
        cycle();
        chk("idle_key_down", bus.key_down, 1'b0);
        chk("idle_col", bus.col, 4'b0000);
        chk("idle_done", bus.done, 1'b1);
        cycle();
        chk("release_done_cnt", done_cnt, 1);

        // Simultaneous press and release in idle: press wins; later press ignored.
        bus.key_code = 4'hF; bus.row = 4'b1000; bus.press_req = 1'b1; bus.release_req = 1'b1;
        cycle();
        bus.press_req = 1'b0; bus.release_req = 1'b0;
        chk("both_busy", bus.busy, 1'b1);
        chk("both_col", bus.col, 4'b1000);
        run(4);
        bus.key_code = 4'h0; bus.press_req = 1'b1;
        cycle();
        bus.press_req = 1'b0;
        run(BC * BP - 6);
        cycle();
        chk("keyF_key_down", bus.key_down, 1'b1);
        chk("keyF_col", bus.col, 4'b1000);
        bus.row = 4'b0001;
        #1;
        chk("keyF_other_row", bus.col, 4'b0000);
        bus.release_req = 1'b1;
        cycle();
        bus.release_req = 1'b0;
        run(BC * BP + 1);
        chk("keyF_idle", bus.key_down, 1'b0);

        // No-bounce instance.
        done0_cnt = 0; busy0_cnt = 0;
        bus0.key_code = 4'h9; bus0.row = 4'b0000; bus0.press_req = 1'b1;
        cycle();
        bus0.press_req = 1'b0;
        chk("nb_key_down", bus0.key_down, 1'b1);
        chk("nb_done_press", bus0.done, 1'b1);
        bus0.row = 4'b0100;
        #1;
        chk("nb_col", bus0.col, 4'b0010);
        cycle();
        chk("nb_done_drop", bus0.done, 1'b0);
        bus0.release_req = 1'b1;
        cycle();
        bus0.release_req = 1'b0;
        chk("nb_idle", bus0.key_down, 1'b0);
        chk("nb_done_release", bus0.done, 1'b1);
        cycle();
        chk("nb_done_cnt", done0_cnt, 2);
        chk("nb_busy_cnt", busy0_cnt, 0);

        // Random traffic on both instances against the reference.
        for (int n = 0; n < 600; n++) begin
            bus.press_req    = ($urandom_range(0, 7) == 0);
            bus.release_req  = ($urandom_range(0, 5) == 0);
            bus.key_code     = 4'($urandom);
            bus.row          = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
            bus0.press_req   = ($urandom_range(0, 3) == 0);
            bus0.release_req = ($urandom_range(0, 3) == 0);
            bus0.key_code    = 4'($urandom);
            bus0.row         = 4'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
